// File: rtl/dti_fifo_async_wr_ctrl_if.sv
// Producer-side bundle for the dti async FIFO write controller:
// push request, status flags, storage write port and Gray pointers.
interface dti_fifo_async_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_req;
   logic                  wr_overflow_clr;
   logic [ADDR_WIDTH:0]   rd_ptr_gray;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [ADDR_WIDTH:0]   wr_ptr_gray;
   logic                  wr_full;
   logic                  wr_almost_full;
   logic [ADDR_WIDTH:0]   wr_level;
   logic                  wr_overflow;

   modport master (
      output wr_req,
      output wr_overflow_clr,
      output rd_ptr_gray,
      input  mem_wr_en,
      input  mem_wr_addr,
      input  wr_ptr_gray,
      input  wr_full,
      input  wr_almost_full,
      input  wr_level,
      input  wr_overflow
   );

   modport slave (
      input  wr_req,
      input  wr_overflow_clr,
      input  rd_ptr_gray,
      output mem_wr_en,
      output mem_wr_addr,
      output wr_ptr_gray,
      output wr_full,
      output wr_almost_full,
      output wr_level,
      output wr_overflow
   );
endinterface

// File: rtl/dti_fifo_async_wr_ctrl.sv
// Write-domain controller for the dti async FIFO: pointers, read-pointer
// synchroniser and producer status (full, almost-full, level, overflow).
module dti_fifo_async_wr_ctrl #(
   parameter int          ADDR_WIDTH   = 4,
   parameter int          SYNC_STAGES  = 2,
   parameter int unsigned AFULL_THRESH = 14
) (
   input logic                      wr_clk,
   input logic                      wr_reset_n,
   dti_fifo_async_wr_ctrl_if.slave  bus
);
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_THRESH);

   logic [AW:0] wr_ptr_bin_q,  wr_ptr_bin_d;
   logic [AW:0] wr_ptr_gray_q, wr_ptr_gray_d;
   logic [AW:0] wr_level_q,    wr_level_d;
   logic        wr_full_q,     wr_full_d;
   logic        wr_afull_q,    wr_afull_d;
   logic        wr_ovf_q,      wr_ovf_d;
   logic [AW:0] sync_q [SYNC_STAGES];
   logic [AW:0] sync_d [SYNC_STAGES];

   logic        push;
   logic [AW:0] rq_gray;
   logic [AW:0] rq_bin;
   logic [AW:0] full_cmp;

   // Writes are blocked while reset is held, even with wr_req high.
   assign push    = bus.wr_req & ~wr_full_q & wr_reset_n;
   assign rq_gray = sync_q[SYNC_STAGES-1];

   always_comb begin
      rq_bin = '0;
      for (int i = 0; i <= AW; i++) begin
         rq_bin[i] = ^(rq_gray >> i);
      end
   end

   assign full_cmp = {~rq_gray[AW:AW-1], rq_gray[AW-2:0]};

   always_comb begin
      sync_d[0] = bus.rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      wr_ptr_bin_d  = wr_ptr_bin_q + {{AW{1'b0}}, push};
      wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
      wr_full_d     = (wr_ptr_gray_d == full_cmp);
      wr_level_d    = wr_ptr_bin_d - rq_bin;
      wr_afull_d    = (wr_level_d >= AFULL_L);
      wr_ovf_d      = wr_ovf_q;
      // Set takes priority over a same-cycle clear.
      if (bus.wr_req & wr_full_q) begin
         wr_ovf_d = 1'b1;
      end else if (bus.wr_overflow_clr) begin
         wr_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge wr_clk or negedge wr_reset_n) begin
      if (!wr_reset_n) begin
         wr_ptr_bin_q  <= '0;
         wr_ptr_gray_q <= '0;
         wr_level_q    <= '0;
         wr_full_q     <= 1'b0;
         wr_afull_q    <= 1'b0;
         wr_ovf_q      <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         wr_ptr_bin_q  <= wr_ptr_bin_d;
         wr_ptr_gray_q <= wr_ptr_gray_d;
         wr_level_q    <= wr_level_d;
         wr_full_q     <= wr_full_d;
         wr_afull_q    <= wr_afull_d;
         wr_ovf_q      <= wr_ovf_d;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign bus.mem_wr_en      = push;
   assign bus.mem_wr_addr    = wr_ptr_bin_q[AW-1:0];
   assign bus.wr_ptr_gray    = wr_ptr_gray_q;
   assign bus.wr_full        = wr_full_q;
   assign bus.wr_almost_full = wr_afull_q;
   assign bus.wr_level       = wr_level_q;
   assign bus.wr_overflow    = wr_ovf_q;

endmodule

// File: tb/tb_dti_fifo_async_wr_ctrl.sv
// Directed-vector bench for dti_fifo_async_wr_ctrl at default parameters.
// Hand-computed expectations plus a small random phase against a read model.
module tb_dti_fifo_async_wr_ctrl;
   logic wr_clk;
   logic wr_reset_n;
   int   n_vec;
   int   n_err;

   dti_fifo_async_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

   dti_fifo_async_wr_ctrl #(
      .ADDR_WIDTH  (4),
      .SYNC_STAGES (2),
      .AFULL_THRESH(14)
   ) dut (
      .wr_clk    (wr_clk),
      .wr_reset_n(wr_reset_n),
      .bus       (bus)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [4:0] wbin;
      logic [4:0] rbin;
      logic [4:0] occ;
      logic       en;
      n_vec = 0;
      n_err = 0;

      // Reset held with a pending request
      wr_reset_n          = 1'b0;
      bus.wr_req          = 1'b1;
      bus.wr_overflow_clr = 1'b0;
      bus.rd_ptr_gray     = '0;
      #2;
      chk("rst_en",    32'(bus.mem_wr_en), 0);
      chk("rst_addr",  32'(bus.mem_wr_addr), 0);
      chk("rst_gray",  32'(bus.wr_ptr_gray), 0);
      chk("rst_full",  32'(bus.wr_full), 0);
      chk("rst_afull", 32'(bus.wr_almost_full), 0);
      chk("rst_lvl",   32'(bus.wr_level), 0);
      chk("rst_ovf",   32'(bus.wr_overflow), 0);
      tick();
      tick();
      chk("rst_hold_lvl", 32'(bus.wr_level), 0);
      bus.wr_req = 1'b0;
      wr_reset_n = 1'b1;
      tick();

      // Partial fill, then asynchronous reset between edges
      bus.wr_req = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_lvl", 32'(bus.wr_level), 5);
      #2;
      wr_reset_n = 1'b0;
      #1;
      chk("arst_lvl",  32'(bus.wr_level), 0);
      chk("arst_gray", 32'(bus.wr_ptr_gray), 0);
      chk("arst_addr", 32'(bus.mem_wr_addr), 0);
      chk("arst_en",   32'(bus.mem_wr_en), 0);
      bus.wr_req = 1'b0;
      tick();
      wr_reset_n = 1'b1;
      tick();

      // Fill 16 with read pointer at 0
      for (int i = 0; i < 16; i++) begin
         bus.wr_req = 1'b1;
         #1;
         chk("fill_en",   32'(bus.mem_wr_en), 1);
         chk("fill_addr", 32'(bus.mem_wr_addr), 32'(i));
         tick();
         chk("fill_lvl",   32'(bus.wr_level), 32'(i + 1));
         chk("fill_afull", 32'(bus.wr_almost_full), 32'(i + 1 >= 14));
         chk("fill_full",  32'(bus.wr_full), 32'(i + 1 == 16));
      end
      chk("full_gray", 32'(bus.wr_ptr_gray), 32'h18);

      // Push while full
      #1;
      chk("ovf_en", 32'(bus.mem_wr_en), 0);
      tick();
      chk("ovf_set",  32'(bus.wr_overflow), 1);
      chk("ovf_gray", 32'(bus.wr_ptr_gray), 32'h18);
      chk("ovf_lvl",  32'(bus.wr_level), 16);
      bus.wr_overflow_clr = 1'b1;
      tick();
      chk("ovf_setwins", 32'(bus.wr_overflow), 1);
      bus.wr_req = 1'b0;
      tick();
      chk("ovf_clr", 32'(bus.wr_overflow), 0);
      bus.wr_overflow_clr = 1'b0;

      // Reader frees 4 slots
      bus.rd_ptr_gray = 5'b00110;
      tick();
      chk("free_e1", 32'(bus.wr_full), 1);
      tick();
      chk("free_e2", 32'(bus.wr_full), 1);
      tick();
      chk("free_e3_full",  32'(bus.wr_full), 0);
      chk("free_e3_lvl",   32'(bus.wr_level), 12);
      chk("free_e3_afull", 32'(bus.wr_almost_full), 0);

      // Wrap: four more pushes land on addresses 0..3
      for (int i = 0; i < 4; i++) begin
         bus.wr_req = 1'b1;
         #1;
         chk("wrap_en",   32'(bus.mem_wr_en), 1);
         chk("wrap_addr", 32'(bus.mem_wr_addr), 32'(i));
         tick();
         chk("wrap_lvl", 32'(bus.wr_level), 32'(13 + i));
      end
      bus.wr_req = 1'b0;
      chk("wrap_gray", 32'(bus.wr_ptr_gray), 32'h1E);
      chk("wrap_full", 32'(bus.wr_full), 1);
      bus.rd_ptr_gray = 5'b11110;
      tick();
      tick();
      chk("drain_e2_lvl", 32'(bus.wr_level), 16);
      tick();
      chk("drain_lvl",   32'(bus.wr_level), 0);
      chk("drain_full",  32'(bus.wr_full), 0);
      chk("drain_afull", 32'(bus.wr_almost_full), 0);

      // Random pushes against a free-running reader model
      wbin = 5'd20;
      rbin = 5'd20;
      for (int n = 0; n < 400; n++) begin
         bus.wr_req = 1'($urandom_range(0, 3) != 0);
         if (rbin != wbin && $urandom_range(0, 2) == 0) rbin = rbin + 5'd1;
         bus.rd_ptr_gray = gray(rbin);
         #1;
         en  = bus.mem_wr_en;
         occ = wbin - rbin;
         if (bus.wr_full) chk("rnd_nofullpush", 32'(en), 0);
         if (en) begin
            chk("rnd_slotfree", 32'(occ < 5'd16), 1);
            chk("rnd_addr", 32'(bus.mem_wr_addr), 32'(wbin[3:0]));
         end
         tick();
         if (en) wbin = wbin + 5'd1;
         occ = wbin - rbin;
         chk("rnd_lvl_ge", 32'(bus.wr_level >= occ), 1);
         chk("rnd_gray", 32'(bus.wr_ptr_gray), 32'(gray(wbin)));
      end
      bus.wr_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
